// File: rtl/fm_phase_demod.sv
// FM phase discriminator with boxcar decimation and an output FIFO.
// The block takes the difference between consecutive CORDIC angles and sums
// 2^DECIM_LOG2 of them. Results are queued for the m00 stream. The input side
// never stalls, so results that arrive when the queue is full are dropped and
// counted.
module fm_phase_demod #(
   parameter int ANGLE_WIDTH            = 16,
   parameter int DECIM_LOG2             = 0,
   parameter int FIFO_DEPTH             = 8,
   parameter int C_M00_AXIS_TDATA_WIDTH = 32
) (
   input  logic                                  s00_axis_aclk,
   input  logic                                  s00_axis_aresetn,
   input  logic                                  s00_axis_tvalid,
   input  logic                                  s00_axis_tlast,
   input  logic [31:0]                           s00_axis_tdata,
   output logic                                  s00_axis_tready,
   input  logic                                  m00_axis_tready,
   output logic                                  m00_axis_tvalid,
   output logic                                  m00_axis_tlast,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
   output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
   output logic                                  overflow_sticky,
   output logic [15:0]                           overflow_count
);

   // Sum of D differences, each a signed ANGLE_WIDTH value, needs log2(D)
   // extra bits and can never overflow.
   localparam int SUM_W = ANGLE_WIDTH + DECIM_LOG2;
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << DECIM_LOG2) - 1);

   typedef enum logic {
      PRIME = 1'b0,
      RUN   = 1'b1
   } state_t;

   // Counter increment that sticks at all ones.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Sign extension of a stored sum onto the output bus.
   function automatic logic [C_M00_AXIS_TDATA_WIDTH-1:0] sext_out(input logic signed [SUM_W-1:0] v);
      return C_M00_AXIS_TDATA_WIDTH'(v);
   endfunction

   // ---------------------------------------------------------------------
   // Input acceptance and discriminator
   // ---------------------------------------------------------------------
   logic                           ready_q;
   logic                           accept;
   logic [ANGLE_WIDTH-1:0]         angle_p0;
   logic [ANGLE_WIDTH-1:0]         prev_angle_q;
   logic [ANGLE_WIDTH-1:0]         prev_angle_d;
   logic [ANGLE_WIDTH-1:0]         diff_raw_p0;
   logic signed [ANGLE_WIDTH-1:0]  diff_p0;
   logic signed [SUM_W-1:0]        sum_p0;
   logic signed [SUM_W-1:0]        acc_q;
   logic signed [SUM_W-1:0]        acc_d;
   logic [CNT_W-1:0]               cnt_q;
   logic [CNT_W-1:0]               cnt_d;
   state_t                         state_q;
   state_t                         state_d;

   logic                           push;
   logic signed [SUM_W-1:0]        push_data;
   logic                           push_last;

   assign angle_p0 = s00_axis_tdata[ANGLE_WIDTH-1:0];

   generate
      if (ANGLE_WIDTH < 32) begin : g_unused_bits
         logic unused_upper;
         assign unused_upper = ^s00_axis_tdata[31:ANGLE_WIDTH];
      end
   endgenerate

   // Ready is a registered "out of reset" flag; the input is never throttled.
   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) ready_q <= 1'b0;
      else                   ready_q <= 1'b1;
   end

   assign s00_axis_tready = ready_q;
   assign accept          = s00_axis_tvalid & ready_q;

   // Modulo subtraction, then read as signed: phase wrap falls out for free.
   assign diff_raw_p0 = angle_p0 - prev_angle_q;
   assign diff_p0     = $signed(diff_raw_p0);
   assign sum_p0      = acc_q + SUM_W'(diff_p0);

   // Next state, decimation accumulator and result push decision.
   always_comb begin
      state_d      = state_q;
      prev_angle_d = prev_angle_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      push         = 1'b0;
      push_data    = sum_p0;
      push_last    = s00_axis_tlast;
      if (accept) begin
         prev_angle_d = angle_p0;
         case (state_q)
            PRIME: begin
               // First sample of a burst only sets the reference phase.
               if (!s00_axis_tlast) state_d = RUN;
            end
            RUN: begin
               if ((cnt_q == CNT_LAST) || s00_axis_tlast) begin
                  // Full block, or a burst end flushing a partial block.
                  push  = 1'b1;
                  acc_d = '0;
                  cnt_d = '0;
                  if (s00_axis_tlast) state_d = PRIME;
               end else begin
                  acc_d = sum_p0;
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: state_d = PRIME;
         endcase
      end
   end

   // State, reference phase and accumulator registers.
   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         state_q      <= PRIME;
         prev_angle_q <= '0;
         acc_q        <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         prev_angle_q <= prev_angle_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
      end
   end

   // ---------------------------------------------------------------------
   // Output FIFO
   // ---------------------------------------------------------------------
   logic [PTR_W:0]     wr_ptr_q;
   logic [PTR_W:0]     rd_ptr_q;
   logic [PTR_W-1:0]   wr_idx;
   logic [PTR_W-1:0]   rd_idx;
   logic               fifo_empty;
   logic               fifo_full;
   logic               pop;
   logic               wr_en;
   logic               drop;
   logic [SUM_W-1:0]   mem_data [FIFO_DEPTH];
   logic               mem_last [FIFO_DEPTH];

   assign wr_idx     = wr_ptr_q[PTR_W-1:0];
   assign rd_idx     = rd_ptr_q[PTR_W-1:0];
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_idx == rd_idx);
   // A pop frees a slot in the same cycle, so full+pop+push is not a drop.
   assign pop        = ~fifo_empty & m00_axis_tready;
   assign wr_en      = push & (~fifo_full | pop);
   assign drop       = push & fifo_full & ~pop;

   // Read and write pointers; the extra MSB separates full from empty.
   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
      end
   end

   // Storage array; contents are meaningless while the FIFO is empty.
   always_ff @(posedge s00_axis_aclk) begin
      if (wr_en) begin
         mem_data[wr_idx] <= push_data;
         mem_last[wr_idx] <= push_last;
      end
   end

   // Drop accounting for results that found the FIFO full.
   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         overflow_sticky <= 1'b0;
         overflow_count  <= '0;
      end else if (drop) begin
         overflow_sticky <= 1'b1;
         overflow_count  <= sat_inc16(overflow_count);
      end
   end

   // Head entry drives the stream; zeroed while empty so reset reads clean.
   assign m00_axis_tvalid = ~fifo_empty;
   assign m00_axis_tlast  = ~fifo_empty & mem_last[rd_idx];
   assign m00_axis_tdata  = fifo_empty ? '0 : sext_out($signed(mem_data[rd_idx]));
   assign m00_axis_tstrb  = '1;

endmodule

// File: tb/tb_fm_phase_demod.sv
// Directed bench for fm_phase_demod: one instance without decimation and one
// decimating by 4 share the same input stimulus; each check looks at the
// instance the scenario targets.
module tb_fm_phase_demod;

   logic        clk;
   logic        rst_n;
   logic        s_valid;
   logic        s_last;
   logic [31:0] s_data;
   logic        m_ready;

   logic        s_ready0, m_valid0, m_last0, ovf_sticky0;
   logic [31:0] m_data0;
   logic [3:0]  m_strb0;
   logic [15:0] ovf_cnt0;

   logic        s_ready2, m_valid2, m_last2, ovf_sticky2;
   logic [31:0] m_data2;
   logic [3:0]  m_strb2;
   logic [15:0] ovf_cnt2;

   int tests;
   int fails;

   fm_phase_demod #(
      .ANGLE_WIDTH(16), .DECIM_LOG2(0), .FIFO_DEPTH(8), .C_M00_AXIS_TDATA_WIDTH(32)
   ) dut0 (
      .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
      .s00_axis_tvalid(s_valid), .s00_axis_tlast(s_last), .s00_axis_tdata(s_data),
      .s00_axis_tready(s_ready0), .m00_axis_tready(m_ready),
      .m00_axis_tvalid(m_valid0), .m00_axis_tlast(m_last0), .m00_axis_tdata(m_data0),
      .m00_axis_tstrb(m_strb0), .overflow_sticky(ovf_sticky0), .overflow_count(ovf_cnt0)
   );

   fm_phase_demod #(
      .ANGLE_WIDTH(16), .DECIM_LOG2(2), .FIFO_DEPTH(8), .C_M00_AXIS_TDATA_WIDTH(32)
   ) dut2 (
      .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
      .s00_axis_tvalid(s_valid), .s00_axis_tlast(s_last), .s00_axis_tdata(s_data),
      .s00_axis_tready(s_ready2), .m00_axis_tready(m_ready),
      .m00_axis_tvalid(m_valid2), .m00_axis_tlast(m_last2), .m00_axis_tdata(m_data2),
      .m00_axis_tstrb(m_strb2), .overflow_sticky(ovf_sticky2), .overflow_count(ovf_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          rst;
      bit          sel2;
      logic [15:0] angle;
      bit          last;
      bit          ev;
      logic [31:0] ed;
      bit          el;
   } vec_t;

   vec_t vecs[40];
   int   nvec;

   task automatic add(input bit rst, input bit sel2, input int angle, input bit last,
                      input bit ev, input int ed, input bit el);
      vecs[nvec] = '{rst, sel2, 16'(angle), last, ev, 32'(ed), el};
      nvec++;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // One accepted beat; returns 1 ns after the edge that takes it.
   task automatic feed(input logic [15:0] angle, input bit last);
      s_valid = 1'b1;
      s_data  = {16'hA5A5, angle};
      s_last  = last;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic do_reset();
      s_valid = 1'b0;
      s_last  = 1'b0;
      rst_n   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Angle sequence whose k-th difference is 3*k.
   function automatic logic [15:0] ang(input int k);
      return 16'(3 * k * (k + 1) / 2);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      tests   = 0;
      fails   = 0;
      nvec    = 0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = '0;
      m_ready = 1'b0;
      rst_n   = 1'b0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check("rst_tready", {31'd0, s_ready0}, 32'd0);
      check("rst_tvalid", {31'd0, m_valid0}, 32'd0);
      check("rst_tlast",  {31'd0, m_last0},  32'd0);
      check("rst_tdata",  m_data0, 32'd0);
      check("rst_sticky", {31'd0, ovf_sticky0}, 32'd0);
      check("rst_count",  {16'd0, ovf_cnt0}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("tready_up", {31'd0, s_ready0}, 32'd1);
      check("tstrb", {28'd0, m_strb0}, 32'hF);

      // No decimation: constant step of 100.
      add(1, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i < 10; i++) add(0, 0, 100 * i, 0, 1, 100, 0);
      // Phase wrap cases.
      add(1, 0, 16'h7FF0, 0, 0, 0, 0);
      add(0, 0, 16'h8010, 0, 1, 32, 0);
      add(0, 0, 16'hFFF0, 0, 1, 32736, 0);
      add(0, 0, 16'h0010, 0, 1, 32, 0);
      add(0, 0, 16'h0000, 0, 1, -16, 0);
      // Decimate by 4, tlast on the 9th sample.
      add(1, 1, 0, 0, 0, 0, 0);
      for (int i = 1; i < 9; i++)
         add(0, 1, 10 * i, (i == 8), (i == 4 || i == 8), 40, (i == 8));
      // Decimate by 4, tlast on the 7th sample flushes a partial sum.
      add(0, 1, 0, 0, 0, 0, 0);
      for (int i = 1; i < 7; i++)
         add(0, 1, 10 * i, (i == 6), (i == 4 || i == 6), (i == 6) ? 20 : 40, (i == 6));
      add(0, 1, 100, 0, 0, 0, 0);
      add(0, 1, 110, 0, 0, 0, 0);

      m_ready = 1'b1;
      for (int i = 0; i < nvec; i++) begin
         logic        av, al;
         logic [31:0] ad;
         if (vecs[i].rst) do_reset();
         feed(vecs[i].angle, vecs[i].last);
         av = vecs[i].sel2 ? m_valid2 : m_valid0;
         al = vecs[i].sel2 ? m_last2  : m_last0;
         ad = vecs[i].sel2 ? m_data2  : m_data0;
         check($sformatf("vec%0d_valid", i), {31'd0, av}, {31'd0, vecs[i].ev});
         if (vecs[i].ev) begin
            check($sformatf("vec%0d_data", i), ad, vecs[i].ed);
            check($sformatf("vec%0d_last", i), {31'd0, al}, {31'd0, vecs[i].el});
         end
      end

      // Overflow: 11 samples, 10 differences, 8 slots.
      do_reset();
      m_ready = 1'b0;
      for (int k = 0; k <= 10; k++) feed(ang(k), 1'b0);
      check("ovf_count",  {16'd0, ovf_cnt0}, 32'd2);
      check("ovf_sticky", {31'd0, ovf_sticky0}, 32'd1);
      @(posedge clk);
      #1;
      check("ovf_hold_data", m_data0, 32'd3);
      m_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         check($sformatf("ovf_pop%0d_valid", k), {31'd0, m_valid0}, 32'd1);
         check($sformatf("ovf_pop%0d_data", k), m_data0, 32'(3 * k));
         @(posedge clk);
         #1;
      end
      check("ovf_drained", {31'd0, m_valid0}, 32'd0);

      // Full FIFO, simultaneous push and pop.
      do_reset();
      m_ready = 1'b0;
      for (int k = 0; k <= 8; k++) feed(ang(k), 1'b0);
      check("full_head", m_data0, 32'd3);
      m_ready = 1'b1;
      feed(ang(9), 1'b0);
      m_ready = 1'b0;
      check("full_pp_count", {16'd0, ovf_cnt0}, 32'd0);
      check("full_pp_sticky", {31'd0, ovf_sticky0}, 32'd0);
      check("full_pp_head", m_data0, 32'd6);
      m_ready = 1'b1;
      for (int k = 2; k <= 9; k++) begin
         check($sformatf("full_pop%0d", k), m_data0, 32'(3 * k));
         @(posedge clk);
         #1;
      end
      check("full_drained", {31'd0, m_valid0}, 32'd0);

      // Asynchronous reset with entries queued and drops counted.
      do_reset();
      m_ready = 1'b0;
      for (int k = 0; k <= 10; k++) feed(ang(k), 1'b0);
      check("pre_rst_count", {16'd0, ovf_cnt0}, 32'd2);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_tvalid", {31'd0, m_valid0}, 32'd0);
      check("arst_tdata",  m_data0, 32'd0);
      check("arst_count",  {16'd0, ovf_cnt0}, 32'd0);
      check("arst_sticky", {31'd0, ovf_sticky0}, 32'd0);
      check("arst_tready", {31'd0, s_ready0}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      m_ready = 1'b1;
      feed(16'd500, 1'b0);
      check("post_rst_prime", {31'd0, m_valid0}, 32'd0);
      feed(16'd450, 1'b0);
      check("post_rst_valid", {31'd0, m_valid0}, 32'd1);
      check("post_rst_data", m_data0, 32'hFFFF_FFCE);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
